// File: rtl/instr_load_port.sv
// Instruction-load receiver: streams words into a small instruction memory and
// serves the CPU fetch stage with a registered, range-checked read port.
module instr_load_port #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              LoadInstructions,
    input  logic [DATA_W-1:0] Instruction,
    input  logic              fetch_en,
    input  logic [31:0]       fetch_addr,
    output logic [DATA_W-1:0] fetch_instr,
    output logic [ADDR_W:0]   load_count,
    output logic              load_done,
    output logic              overflow,
    output logic              cpu_hold
);

    // Handshake: LoadInstructions qualifies Instruction as valid for that cycle.
    // There is no ready; the port accepts every valid word, dropping it only
    // when memory is full.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W:0]   ptr, ptr_n;
    logic              ovf_n;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [ADDR_W-1:0] ridx;
    logic              rd_ok;
    logic              unused_addr_bits;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign ridx             = fetch_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^fetch_addr[1:0];

    // A restart edge is still READY in the register but already owns mem[0].
    assign rd_ok = (state == READY) && !LoadInstructions
                && (fetch_addr[31:ADDR_W+2] == '0)
                && ({1'b0, ridx} < ptr);

    assign load_count = ptr;
    assign load_done  = (state == READY);
    assign cpu_hold   = (state != READY);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        ovf_n   = overflow;
        we      = 1'b0;
        waddr   = ptr[ADDR_W-1:0];
        case (state)
            IDLE, READY: begin
                if (LoadInstructions) begin
                    we      = 1'b1;
                    waddr   = '0;
                    ptr_n   = (ADDR_W+1)'(1);
                    ovf_n   = 1'b0;
                    state_n = LOAD;
                end
            end
            LOAD: begin
                if (!LoadInstructions) begin
                    state_n = READY;
                end else if (!ptr[ADDR_W]) begin
                    we    = 1'b1;
                    ptr_n = ptr + (ADDR_W+1)'(1);
                end else begin
                    ovf_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            state       <= IDLE;
            ptr         <= '0;
            overflow    <= 1'b0;
            fetch_instr <= '0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            overflow <= ovf_n;
            if (fetch_en) begin
                fetch_instr <= rd_ok ? mem[ridx] : '0;
            end
        end
    end

    // Memory contents survive reset; only the pointer is cleared.
    always_ff @(posedge clk) begin
        if (Reset && we) begin
            mem[waddr] <= Instruction;
        end
    end

endmodule

// File: tb/tb_instr_load_port.sv
// Bench for instr_load_port: a small memory model predicts every fetch result,
// expectations are queued when a fetch is issued and compared when it returns.
module tb_instr_load_port;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 6;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              Reset = 1'b0;
    logic              LoadInstructions = 1'b0;
    logic [DATA_W-1:0] Instruction = '0;
    logic              fetch_en = 1'b0;
    logic [31:0]       fetch_addr = '0;
    logic [DATA_W-1:0] fetch_instr;
    logic [ADDR_W:0]   load_count;
    logic              load_done;
    logic              overflow;
    logic              cpu_hold;

    instr_load_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk              (clk),
        .Reset            (Reset),
        .LoadInstructions (LoadInstructions),
        .Instruction      (Instruction),
        .fetch_en         (fetch_en),
        .fetch_addr       (fetch_addr),
        .fetch_instr      (fetch_instr),
        .load_count       (load_count),
        .load_done        (load_done),
        .overflow         (overflow),
        .cpu_hold         (cpu_hold)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] exp_q[$];

    logic [31:0] prog [11] = '{32'h200101A7, 32'h2002005C, 32'h20030014, 32'h00221820,
                               32'h00622022, 32'h00832824, 32'h00A43025, 32'h10C70002,
                               32'hAC050004, 32'h8C060004, 32'h00E24020};

    logic [DATA_W-1:0] model_mem [DEPTH];
    int   model_count = 0;
    logic model_ovf   = 1'b0;
    logic model_ready = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_fetch(input logic [31:0] addr);
        int idx;
        idx = int'(addr[ADDR_W+1:2]);
        if (!model_ready || addr[31:ADDR_W+2] != '0 || idx >= model_count) return '0;
        return model_mem[idx];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        Reset = 1'b0; LoadInstructions = 1'b0; fetch_en = 1'b0;
        model_count = 0; model_ovf = 1'b0; model_ready = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        Reset = 1'b1;
    endtask

    // Drive one word at the negedge; the model applies the same accept/drop rule.
    task automatic drive_word(input logic [31:0] w);
        @(negedge clk);
        LoadInstructions = 1'b1;
        Instruction      = w;
        if (model_ready || model_count == 0) begin
            model_count = 0;
            model_ovf   = 1'b0;
        end
        model_ready = 1'b0;
        if (model_count < DEPTH) begin
            model_mem[model_count] = w;
            model_count++;
        end else begin
            model_ovf = 1'b1;
        end
    endtask

    task automatic finish_load();
        @(posedge clk); #1;
        check("done_before_fall", 32'(load_done), 32'd0);
        @(negedge clk);
        LoadInstructions = 1'b0;
        @(posedge clk); #1;
        model_ready = 1'b1;
        check("done_after_fall", 32'(load_done), 32'd1);
        check("hold_after_fall", 32'(cpu_hold), 32'd0);
        check("count", 32'(load_count), 32'(model_count));
        check("overflow", 32'(overflow), 32'(model_ovf));
    endtask

    task automatic fetch(input logic [31:0] addr);
        @(negedge clk);
        fetch_en   = 1'b1;
        fetch_addr = addr;
        exp_q.push_back(model_fetch(addr));
        @(posedge clk); #1;
        check("fetch", fetch_instr, exp_q.pop_front());
        @(negedge clk);
        fetch_en = 1'b0;
    endtask

    initial begin
        // Reset state
        do_reset();
        @(posedge clk); #1;
        check("rst_instr", fetch_instr, 32'd0);
        check("rst_count", 32'(load_count), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_ovf", 32'(overflow), 32'd0);
        fetch(32'd0);

        // 11-word program
        for (int i = 0; i < 11; i++) drive_word(prog[i]);
        finish_load();
        fetch(32'd0);
        fetch(32'd40);
        fetch(32'd44);
        fetch(32'h100);
        fetch(32'd4);
        @(posedge clk); #1;
        check("hold_value", fetch_instr, prog[1]);

        // Overflow: 66 words into a 64-word memory
        for (int i = 0; i < DEPTH + 2; i++) drive_word($urandom);
        finish_load();
        fetch(32'd252);
        fetch(32'd0);
        fetch(32'd4);
        fetch(32'd256);

        // New short load clears overflow
        drive_word(32'hDEAD0001);
        drive_word(32'hDEAD0002);
        finish_load();
        fetch(32'd4);
        fetch(32'd8);

        // Reset in the middle of a load
        for (int i = 0; i < 5; i++) drive_word(32'hA5A50000 + 32'(i));
        do_reset();
        @(posedge clk); #1;
        check("midrst_count", 32'(load_count), 32'd0);
        check("midrst_hold", 32'(cpu_hold), 32'd1);
        check("midrst_done", 32'(load_done), 32'd0);
        fetch(32'd0);

        // Restart from READY with a fetch on the same edge
        for (int i = 0; i < 3; i++) drive_word(prog[i]);
        finish_load();
        fetch(32'd8);
        drive_word(32'hCAFE0123);
        fetch_en   = 1'b1;
        fetch_addr = 32'd0;
        exp_q.push_back(model_fetch(32'd0));
        @(posedge clk); #1;
        check("restart_fetch", fetch_instr, exp_q.pop_front());
        check("restart_hold", 32'(cpu_hold), 32'd1);
        check("restart_count", 32'(load_count), 32'd1);
        @(negedge clk);
        fetch_en = 1'b0;
        LoadInstructions = 1'b0;
        @(posedge clk); #1;
        model_ready = 1'b1;
        check("restart_done", 32'(load_done), 32'd1);
        fetch(32'd0);
        fetch(32'd4);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_load_port.md
Name: instr_load_port

Overview:
- CPU-side receiver for the serial instruction-load interface: accepts one 32-bit word per clock while LoadInstructions is high and writes it into instruction memory at auto-incrementing word addresses.
- Serves the CPU fetch stage with a registered read port.
- Holds the core idle via cpu_hold until a load completes.
- Sits between the bench/boot-loader stimulus and the datapath PC/fetch logic.

Parameters:
DATA_W, 32, instruction word width
ADDR_W, 6, word-address width; memory depth = 2**ADDR_W words (default 64)

Ports:
clk  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-low reset (Reset=0 resets on next rising edge)
LoadInstructions  input  1  load strobe; high = Instruction valid this cycle
Instruction  input  DATA_W  instruction word to store
fetch_en  input  1  fetch request from CPU
fetch_addr  input  32  byte-address PC; bits [1:0] ignored
fetch_instr  output  DATA_W  registered fetched word
load_count  output  ADDR_W+1  number of words stored in current program
load_done  output  1  high in READY state
overflow  output  1  sticky: a word was dropped because memory was full
cpu_hold  output  1  high whenever state is not READY; CPU must not advance PC

Behaviour:
- Reset (Reset=0 at rising edge):
  - state=IDLE, write pointer=0, load_count=0, fetch_instr=0, load_done=0, overflow=0, cpu_hold=1.
  - Memory array is not cleared.
- State machine:
  - IDLE:
    - LoadInstructions=1 -> write Instruction to mem[0], pointer=1, count=1, go to LOAD.
    - Otherwise stay in IDLE.
  - LOAD:
    - Each cycle with LoadInstructions=1 and pointer<2**ADDR_W: write mem[pointer], pointer+1, count+1.
    - LoadInstructions=0 -> go to READY next cycle; no write that cycle.
  - READY:
    - load_done=1, cpu_hold=0.
    - LoadInstructions=1 -> restart: clear overflow, write mem[0], pointer=1, count=1, go to LOAD. cpu_hold rises the same edge.
- Full boundary:
  - pointer==2**ADDR_W with LoadInstructions=1: word dropped, no wrap, overflow set to 1 (sticky until reset or new load).
  - load_count saturates at 2**ADDR_W.
- Fetch:
  - Word index = fetch_addr[ADDR_W+1:2].
  - Latency 1 cycle: fetch_instr updates on the edge after fetch_en=1; it holds its value when fetch_en=0.
  - Returns 0 (NOP) if state!=READY, fetch_addr[31:ADDR_W+2]!=0, or index>=load_count.
  - Otherwise returns mem[index].
- Simultaneous events:
  - Fetch during LOAD or on the restart edge returns 0. There is no read-during-write hazard path.
  - Reset has priority over load and fetch.
- Reset mid-load: aborts the load; count=0, so previously written words are unreadable until reloaded.

Test Plan:
- Reset=0 one cycle, then idle -> fetch_instr=0, load_count=0, load_done=0, cpu_hold=1, overflow=0.
- Load 11 words starting 0x200101A7, 0x2002005C, ..., last 0x00E24020, then drop LoadInstructions:
  - load_count=11.
  - load_done=1 and cpu_hold=0 exactly one cycle after the strobe falls.
  - fetch_addr=0 -> 0x200101A7 next cycle.
  - fetch_addr=40 -> 0x00E24020.
- After the 11-word load:
  - fetch_addr=44 (index 11>=count) -> 0.
  - fetch_addr=0x100 (upper bits set) -> 0.
  - fetch_en=0 -> fetch_instr holds previous value.
- Stream 66 words with default ADDR_W=6:
  - load_count=64, overflow=1.
  - fetch_addr=252 -> word 63; words 64 and 65 absent.
  - A new 2-word load clears overflow, load_count=2.
- Assert Reset=0 after word 5 of a load -> state IDLE, load_count=0, fetch_addr=0 -> 0, cpu_hold=1.
- In READY, raise LoadInstructions with fetch_en=1 on the same edge:
  - fetch_instr=0, cpu_hold=1, load_count=1.
  - mem[0] holds the new word after the next READY.
